pipeline_cmd_sched: RTL

PIPELINE_CMD_SCHED -- requirements
Module: pipeline_cmd_sched

---
 rtl/pipeline_cmd_sched.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_cmd_sched.sv
// pipeline_cmd_sched
// Buffers control commands for an array of DSP blocks in a small FIFO and
// issues them one at a time while the processing pipeline is idle. Write
// strobes are held until the core acknowledges them. A missing ack traps the
// scheduler in a sticky error state that only reset clears.
module pipeline_cmd_sched #(
    parameter int n_blocks       = 256,
    parameter int reg_addr_width = 4,
    parameter int data_width     = 16,
    parameter int instr_width    = 32,
    parameter int fifo_depth     = 8,
    parameter int ack_timeout    = 255,
    localparam int BW = $clog2(n_blocks),
    localparam int RW = reg_addr_width,
    localparam int IW = instr_width
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [BW-1:0]         cmd_block,
    input  logic [RW-1:0]         cmd_reg,
    input  logic [IW-1:0]         cmd_payload,
    input  logic                  pipe_ready,
    input  logic                  in_valid,
    output logic [BW-1:0]         block_target,
    output logic [BW+RW-1:0]      reg_target,
    output logic [IW-1:0]         instr_val,
    output logic [data_width-1:0] ctrl_data,
    output logic                  instr_write,
    output logic                  reg_write,
    output logic                  reg_update,
    output logic                  alloc_sram_delay,
    input  logic                  instr_write_ack,
    input  logic                  reg_write_ack,
    output logic                  busy,
    output logic                  error,
    output logic [15:0]           n_issued
);

    localparam int AW = $clog2(fifo_depth);
    localparam int EW = 2 + BW + RW + IW;
    localparam int TW = $clog2(ack_timeout + 1);
    localparam logic [AW:0]   PTR_ONE      = (AW+1)'(1);
    localparam logic [TW-1:0] CNT_ONE      = TW'(1);
    // The counter holds 0 in the first WAIT_ACK cycle, so this value marks
    // the last cycle of the allowed ack window.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ack_timeout - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        ERR      = 2'd3
    } state_t;

    logic [EW-1:0]   fifoMem_q [fifo_depth];
    logic [AW:0]     wrPtr_q;
    logic [AW:0]     rdPtr_q;
    logic            fifoEmpty;
    logic            fifoFull;
    logic            push;
    logic            pop;
    logic [EW-1:0]   headEntry;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [BW-1:0]   block_q, block_d;
    logic [RW-1:0]   regAddr_q, regAddr_d;
    logic [IW-1:0]   payload_q, payload_d;
    logic [3:0]      strobe_q, strobe_d;
    logic [TW-1:0]   timeoutCnt_q, timeoutCnt_d;
    logic            error_q, error_d;
    logic [15:0]     nIssued_q, nIssued_d;
    logic            ackHit;

    // The pointers carry an extra wrap bit so that full and empty can be
    // told apart without a separate occupancy counter.
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                       (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign cmd_ready = !fifoFull && (state_q != ERR);
    assign push      = cmd_valid && cmd_ready;
    assign headEntry = fifoMem_q[rdPtr_q[AW-1:0]];

    // Only the ack that matches the outstanding write can complete it.
    assign ackHit = (op_q == 2'd0) ? instr_write_ack : reg_write_ack;

    // Command storage; the read pointer alone decides what is valid, so the
    // array itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q[AW-1:0]] <= {cmd_op, cmd_block, cmd_reg, cmd_payload};
        end
    end

    // FIFO pointers; a push and a pop in the same cycle both take effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
        end
    end

    // Scheduler state, issued-command latches, strobes and status counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            block_q      <= '0;
            regAddr_q    <= '0;
            payload_q    <= '0;
            strobe_q     <= '0;
            timeoutCnt_q <= '0;
            error_q      <= 1'b0;
            nIssued_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            block_q      <= block_d;
            regAddr_q    <= regAddr_d;
            payload_q    <= payload_d;
            strobe_q     <= strobe_d;
            timeoutCnt_q <= timeoutCnt_d;
            error_q      <= error_d;
            nIssued_q    <= nIssued_d;
        end
    end

    // Next-state logic: pick up the FIFO head only when the pipeline is idle
    // and not sampling, then drive the op-selected strobe from a register so
    // it rises one edge after the head is latched.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        block_d      = block_q;
        regAddr_d    = regAddr_q;
        payload_d    = payload_q;
        strobe_d     = '0;
        timeoutCnt_d = timeoutCnt_q;
        error_d      = error_q;
        nIssued_d    = nIssued_q;
        pop          = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifoEmpty && pipe_ready && !in_valid) begin
                    pop = 1'b1;
                    {op_d, block_d, regAddr_d, payload_d} = headEntry;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                strobe_d[op_q] = 1'b1;
                if (op_q[1]) begin
                    state_d   = IDLE;
                    nIssued_d = nIssued_q + 16'd1;
                end else begin
                    state_d      = WAIT_ACK;
                    timeoutCnt_d = '0;
                end
            end
            WAIT_ACK: begin
                if (ackHit) begin
                    state_d   = IDLE;
                    nIssued_d = nIssued_q + 16'd1;
                end else if (timeoutCnt_q == TIMEOUT_LAST) begin
                    state_d = ERR;
                    error_d = 1'b1;
                end else begin
                    strobe_d     = strobe_q;
                    timeoutCnt_d = timeoutCnt_q + CNT_ONE;
                end
            end
            ERR: begin
                error_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign block_target     = block_q;
    assign reg_target       = {block_q, regAddr_q};
    assign instr_val        = payload_q;
    assign ctrl_data        = payload_q[data_width-1:0];
    assign instr_write      = strobe_q[0];
    assign reg_write        = strobe_q[1];
    assign reg_update       = strobe_q[2];
    assign alloc_sram_delay = strobe_q[3];
    assign busy             = !fifoEmpty || (state_q != IDLE);
    assign error            = error_q;
    assign n_issued         = nIssued_q;

endmodule
